// File: rtl/frame_renderer_if.sv
// frame_renderer_if: controller position/score inputs to the renderer and its pixel-write outputs.
interface frame_renderer_if;
  logic       game_over;
  logic [7:0] man_x;
  logic [6:0] man_y;
  logic [7:0] board0_x;
  logic [7:0] board1_x;
  logic [7:0] board2_x;
  logic [7:0] board3_x;
  logic [6:0] board0_y;
  logic [6:0] board1_y;
  logic [6:0] board2_y;
  logic [6:0] board3_y;
  logic [7:0] vga_x;
  logic [6:0] vga_y;
  logic [2:0] colour;
  logic       plot;
  logic       busy;
  logic       frame_done;
  modport master (
    output game_over, man_x, man_y, board0_x, board1_x, board2_x, board3_x,
           board0_y, board1_y, board2_y, board3_y,
    input  vga_x, vga_y, colour, plot, busy, frame_done
  );
  modport slave (
    input  game_over, man_x, man_y, board0_x, board1_x, board2_x, board3_x,
           board0_y, board1_y, board2_y, board3_y,
    output vga_x, vga_y, colour, plot, busy, frame_done
  );
endinterface

// File: rtl/frame_renderer.sv
// frame_renderer: renders the latched board/man snapshot as 160x120 VGA pixel writes, one per cycle.
// Define ERASE_PREV_EN to erase only the previous frame's objects instead of clearing the whole screen.
module frame_renderer #(
  parameter int         FRAME_TICKS = 833333,
  parameter int         SCR_W       = 160,
  parameter int         SCR_H       = 120,
  parameter int         BOARD_HALF  = 23,
  parameter int         BOARD_H     = 2,
  parameter logic [2:0] BG_COL      = 3'b000,
  parameter logic [2:0] BOARD_COL   = 3'b010,
  parameter logic [2:0] MAN_COL     = 3'b111
) (
  input logic             clk,
  input logic             rst,
  frame_renderer_if.slave bus
);
  localparam int CW = $clog2(FRAME_TICKS);
  typedef enum logic [2:0] {IDLE, LATCH, CLEAR, ERASE, BOARD, MAN} state_t;
  state_t state, state_n;
  logic [CW-1:0] cnt;
  logic tick, drawing, is_man, last_col, last_row, last_pix, on_scr;
  logic [7:0] col, col_n, obj_x, x_n;
  logic [6:0] row, row_n, obj_y, y_n;
  logic [2:0] obj, obj_n, colour_n;
  logic [8:0] px;
  logic [7:0] py;
  logic plot_n, busy_n, done_n;
  // object slots 0..3 are the boards, slot 4 is the man
  logic [7:0] snap_x [5];
  logic [6:0] snap_y [5];
  logic snap_go;
  assign tick = cnt == CW'(FRAME_TICKS - 1);
`ifdef ERASE_PREV_EN
  logic [7:0] prev_x [5];
  logic [6:0] prev_y [5];
  always_ff @(posedge clk) begin
    if (rst) begin
      prev_x <= '{default: '0};
      prev_y <= '{default: '0};
    end else if (done_n) begin
      prev_x <= snap_x;
      prev_y <= snap_y;
    end
  end
  assign obj_x = state == ERASE ? prev_x[obj] : snap_x[obj];
  assign obj_y = state == ERASE ? prev_y[obj] : snap_y[obj];
`else
  assign obj_x = snap_x[obj];
  assign obj_y = snap_y[obj];
`endif
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt <= '0;
      col <= '0;
      row <= '0;
      obj <= '0;
    end else begin
      state <= state_n;
      cnt <= tick ? '0 : cnt + CW'(1);
      col <= col_n;
      row <= row_n;
      obj <= obj_n;
    end
  end
  always_comb begin
    state_n = state;
    case (state)
      IDLE:  state_n = tick ? LATCH : IDLE;
`ifdef ERASE_PREV_EN
      LATCH: state_n = ERASE;
`else
      LATCH: state_n = CLEAR;
`endif
      CLEAR: state_n = last_pix ? BOARD : CLEAR;
      ERASE: state_n = last_pix && obj == 3'd4 ? BOARD : ERASE;
      BOARD: state_n = last_pix && obj == 3'd3 ? MAN : BOARD;
      MAN:   state_n = last_pix ? IDLE : MAN;
      default: state_n = IDLE;
    endcase
  end
  // raster iterator: col inner, row outer, obj outermost; column maths wraps in 9 bits
  always_comb begin
    drawing = state inside {CLEAR, ERASE, BOARD, MAN};
    is_man = state == MAN || (state == ERASE && obj == 3'd4);
    last_col = state == CLEAR ? col == 8'(SCR_W - 1) : col == (is_man ? 8'd4 : 8'(2 * BOARD_HALF));
    last_row = state == CLEAR ? row == 7'(SCR_H - 1) : row == (is_man ? 7'd4 : 7'(BOARD_H - 1));
    last_pix = last_col && last_row;
    col_n = !drawing || last_col ? '0 : col + 8'd1;
    row_n = !drawing || last_pix ? '0 : last_col ? row + 7'd1 : row;
    obj_n = !drawing || (last_pix && is_man) ? '0 : last_pix && state != CLEAR ? obj + 3'd1 : obj;
    px = state == CLEAR ? {1'b0, col} : {1'b0, obj_x} - (is_man ? 9'd2 : 9'(BOARD_HALF)) + {1'b0, col};
    py = state == CLEAR ? {1'b0, row} : {1'b0, obj_y} + {1'b0, row};
    on_scr = !px[8] && px[7:0] < 8'(SCR_W) && py < 8'(SCR_H);
  end
  always_comb begin
    plot_n = drawing && on_scr;
    x_n = px[7:0];
    y_n = py[6:0];
    colour_n = state == BOARD ? BOARD_COL : state == MAN ? (snap_go ? 3'b100 : MAN_COL) : BG_COL;
    busy_n = state != IDLE;
    done_n = state == MAN && last_pix;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      snap_x <= '{default: '0};
      snap_y <= '{default: '0};
      snap_go <= 1'b0;
    end else if (state == LATCH) begin
      snap_x <= '{bus.board0_x, bus.board1_x, bus.board2_x, bus.board3_x, bus.man_x};
      snap_y <= '{bus.board0_y, bus.board1_y, bus.board2_y, bus.board3_y, bus.man_y};
      snap_go <= bus.game_over;
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      bus.vga_x <= '0;
      bus.vga_y <= '0;
      bus.colour <= '0;
      bus.plot <= 1'b0;
      bus.busy <= 1'b0;
      bus.frame_done <= 1'b0;
    end else begin
      bus.vga_x <= x_n;
      bus.vga_y <= y_n;
      bus.colour <= colour_n;
      bus.plot <= plot_n;
      bus.busy <= busy_n;
      bus.frame_done <= done_n;
    end
  end
endmodule

// File: tb/tb_frame_renderer.sv
// tb_frame_renderer: frames of directed and random positions checked against a painter's-order model
// of every expected pixel write, plus frame timing, tick dropping and mid-frame reset.
module tb_frame_renderer;
  localparam int TICKS = 4000;
`ifdef ERASE_PREV_EN
  localparam int FL = 803;
`else
  localparam int FL = 19602;
`endif
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  frame_renderer_if bus();
  frame_renderer #(.FRAME_TICKS(TICKS)) dut (.clk(clk), .rst(rst), .bus(bus));

  int n_chk = 0, n_fail = 0, cyc = 0, first_plot = -1, rel = 0, last_end = 0;
  logic [17:0] got[$];
  logic [17:0] exp_q[$];
  int done_q[$];
  logic [7:0] bx[4], sbx[4], mx, smx;
  logic [6:0] by[4], sby[4], my, smy;
  logic go, sgo;
`ifdef ERASE_PREV_EN
  logic [7:0] pbx[4], pmx;
  logic [6:0] pby[4], pmy;
`endif

  always @(posedge clk) begin
    #1;
    cyc = cyc + 1;
    if (bus.plot) begin
      got.push_back({bus.vga_x, bus.vga_y, bus.colour});
      if (first_plot < 0) first_plot = cyc;
    end
    if (bus.frame_done) done_q.push_back(cyc);
  end

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] req);
    n_chk++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", tag, act, act, req, req);
    end
  endtask

  task automatic wait_cyc(input int t);
    while (cyc < t) @(negedge clk);
  endtask

  task automatic drive();
    bus.board0_x = bx[0]; bus.board1_x = bx[1]; bus.board2_x = bx[2]; bus.board3_x = bx[3];
    bus.board0_y = by[0]; bus.board1_y = by[1]; bus.board2_y = by[2]; bus.board3_y = by[3];
    bus.man_x = mx; bus.man_y = my; bus.game_over = go;
  endtask

  task automatic rand_pos();
    for (int b = 0; b < 4; b++) begin
      bx[b] = 8'($urandom_range(0, 255));
      by[b] = 7'($urandom_range(0, 127));
    end
    mx = 8'($urandom_range(0, 255));
    my = 7'($urandom_range(0, 119));
    go = 1'($urandom_range(0, 1));
  endtask

  task automatic paint(input int x0, input int y0, input int w, input int h, input logic [2:0] c);
    for (int r = 0; r < h; r++)
      for (int k = 0; k < w; k++)
        if (x0 + k >= 0 && x0 + k < 160 && y0 + r < 120)
          exp_q.push_back({8'(x0 + k), 7'(y0 + r), c});
  endtask

  task automatic build_exp();
    exp_q.delete();
`ifdef ERASE_PREV_EN
    for (int b = 0; b < 4; b++) paint(int'(pbx[b]) - 23, int'(pby[b]), 47, 2, 3'b000);
    paint(int'(pmx) - 2, int'(pmy), 5, 5, 3'b000);
`else
    paint(0, 0, 160, 120, 3'b000);
`endif
    for (int b = 0; b < 4; b++) paint(int'(sbx[b]) - 23, int'(sby[b]), 47, 2, 3'b010);
    paint(int'(smx) - 2, int'(smy), 5, 5, sgo ? 3'b100 : 3'b111);
  endtask

  task automatic run_frame(input bit do_reset);
    int s, mism;
    s = rel + ((last_end - rel) / TICKS + 1) * TICKS;
    sbx = bx; sby = by; smx = mx; smy = my; sgo = go;
    build_exp();
    got.delete();
    done_q.delete();
    first_plot = -1;
    wait_cyc(s + 1);
    check("busy_start", bus.busy, 1);
    check("plot_latch", bus.plot, 0);
    wait_cyc(s + 10);
    rand_pos();
    mx = smx + 8'd20;
    go = ~sgo;
    drive();
`ifndef ERASE_PREV_EN
    wait_cyc(s + TICKS + 1);
    check("tick_drop_busy", bus.busy, 1);
`endif
    if (do_reset) begin
      wait_cyc(s + FL - 100);
      rst = 1'b1;
      wait_cyc(s + FL - 99);
      check("rst_plot", bus.plot, 0);
      check("rst_busy", bus.busy, 0);
      check("rst_done", bus.frame_done, 0);
      check("rst_x", bus.vga_x, 0);
      rst = 1'b0;
      rel = cyc;
      last_end = cyc;
`ifdef ERASE_PREV_EN
      for (int b = 0; b < 4; b++) begin pbx[b] = '0; pby[b] = '0; end
      pmx = '0; pmy = '0;
`endif
    end else begin
      wait_cyc(s + FL);
      check("done_pulse", bus.frame_done, 1);
      wait_cyc(s + FL + 1);
      check("busy_end", bus.busy, 0);
      check("done_once", done_q.size(), 1);
      check("first_plot", first_plot, s + 2);
      check("nwrites", got.size(), exp_q.size());
      mism = 0;
      for (int i = 0; i < exp_q.size() && i < got.size(); i++) if (got[i] !== exp_q[i]) mism++;
      check("wr_seq", mism, 0);
      last_end = s + FL;
`ifdef ERASE_PREV_EN
      pbx = sbx; pby = sby; pmx = smx; pmy = smy;
`endif
    end
  endtask

  initial begin
    int n_b2, n_b0, n_man, xmin, xmax;
    logic [7:0] x;
    logic [6:0] y;
    logic [2:0] c;
    rand_pos();
    drive();
`ifdef ERASE_PREV_EN
    for (int b = 0; b < 4; b++) begin pbx[b] = '0; pby[b] = '0; end
    pmx = '0; pmy = '0;
`endif
    wait_cyc(3);
    check("reset_plot", bus.plot, 0);
    check("reset_busy", bus.busy, 0);
    check("reset_done", bus.frame_done, 0);
    check("reset_x", bus.vga_x, 0);
    check("reset_colour", bus.colour, 0);
    rst = 1'b0;
    rel = cyc;
    last_end = cyc;
    bx[0] = 8'd10;  by[0] = 7'd20;
    by[1] = 7'd125;
    bx[2] = 8'd80;  by[2] = 7'd64;
    by[3] = 7'd127;
    mx = 8'd80; my = 7'd118; go = 1'b0;
    drive();
    run_frame(1'b0);
    n_b2 = 0; n_b0 = 0; n_man = 0; xmin = 255; xmax = 0;
    for (int i = 0; i < got.size(); i++) begin
      {x, y, c} = got[i];
      if (c == 3'b010 && (y == 7'd64 || y == 7'd65)) begin
        n_b2++;
        if (int'(x) < xmin) xmin = int'(x);
        if (int'(x) > xmax) xmax = int'(x);
      end
      if (c == 3'b010 && (y == 7'd20 || y == 7'd21)) n_b0++;
      if (c == 3'b111) n_man++;
    end
    check("board2_px", n_b2, 94);
    check("board2_xmin", xmin, 57);
    check("board2_xmax", xmax, 103);
    check("board0_clip", n_b0, 68);
    check("man_clip", n_man, 10);
`ifdef ERASE_PREV_EN
    bx[0] = 8'd10; by[0] = 7'd20; bx[1] = sbx[1]; by[1] = 7'd125;
    bx[2] = 8'd80; by[2] = 7'd64; bx[3] = sbx[3]; by[3] = 7'd127;
    mx = 8'd90; my = 7'd118; go = 1'b0;
    drive();
    run_frame(1'b0);
    n_man = 0;
    for (int i = 0, stop = 0; i < got.size() && stop == 0; i++) begin
      {x, y, c} = got[i];
      if (c == 3'b010) stop = 1;
      else if (c == 3'b000 && x >= 8'd78 && x <= 8'd82 && y >= 7'd118) n_man++;
    end
    check("erase_man", n_man, 10);
`endif
    rand_pos();
    drive();
    run_frame(1'b1);
    rand_pos();
    go = 1'b1;
    drive();
    run_frame(1'b0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
